// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the 16-bit Bananachine datapath: sequences
// fetch/decode/execute/memory phases and drives all datapath selects.
module multicycle_controller #(
  parameter int WIDTH         = 16,
  parameter int OP_BITS       = 4,
  parameter int ALU_CONT_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [OP_BITS-1:0]       op_code,
  input  logic [OP_BITS-1:0]       ext_op_code,
  input  logic [OP_BITS-1:0]       A_index,
  input  logic [WIDTH-1:0]         psr_flags,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_addr_src,
  output logic                     ir_load,
  output logic                     alu_A_src,
  output logic                     alu_B_src,
  output logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic                     reg_write,
  output logic [1:0]               reg_write_src,
  output logic                     psr_write,
  output logic                     pc_en,
  output logic [1:0]               pc_src,
  output logic                     instr_done,
  output logic [1:0]               state_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_MEM    = 2'b11
  } state_t;

  localparam logic [OP_BITS-1:0] OP_RTYPE  = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_SPEC   = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_SHIFT  = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_BCOND  = OP_BITS'(12);
  localparam logic [OP_BITS-1:0] OP_LUI    = OP_BITS'(15);
  localparam logic [OP_BITS-1:0] EXT_LOAD  = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] EXT_STOR  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] EXT_JAL   = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] EXT_JCOND = OP_BITS'(12);

  state_t r_state;
  state_t w_next;
  logic   w_is_mem;
  logic   w_cond;
  logic   w_unused;

  // Only C, L, F, Z and N are consulted; the remaining PSR bits are don't-care.
  assign w_unused = &{1'b0, psr_flags};

  function automatic logic cond_true(input logic [3:0] c, input logic [WIDTH-1:0] f);
    logic fc, fl, ff, fz, fn;
    fc = f[0];
    fl = f[2];
    ff = f[5];
    fz = f[6];
    fn = f[7];
    case (c)
      4'b0000: cond_true = fz;
      4'b0001: cond_true = ~fz;
      4'b0010: cond_true = fc;
      4'b0011: cond_true = ~fc;
      4'b0100: cond_true = fl;
      4'b0101: cond_true = ~fl;
      4'b0110: cond_true = fn;
      4'b0111: cond_true = ~fn;
      4'b1000: cond_true = ff;
      4'b1001: cond_true = ~ff;
      4'b1010: cond_true = ~fl & ~fz;
      4'b1011: cond_true = fl | fz;
      4'b1100: cond_true = ~fn & ~fz;
      4'b1101: cond_true = fn | fz;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  // ALU control word: 2-bit class prefix over the op field, upper bits zero.
  function automatic logic [ALU_CONT_BITS-1:0] alu_code(input logic [1:0] pfx,
                                                        input logic [OP_BITS-1:0] code);
    alu_code = '0;
    alu_code[OP_BITS+1:0] = {pfx, code};
  endfunction

  assign w_is_mem = (op_code == OP_SPEC) &&
                    ((ext_op_code == EXT_LOAD) || (ext_op_code == EXT_STOR));
  assign w_cond   = cond_true(A_index[3:0], psr_flags);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_is_mem ? S_MEM : S_EXEC;
      S_EXEC:   w_next = S_FETCH;
      S_MEM:    if (mem_ready) w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_src  = 1'b0;
    ir_load       = 1'b0;
    alu_A_src     = 1'b0;
    alu_B_src     = 1'b0;
    alu_cont      = '0;
    reg_write     = 1'b0;
    reg_write_src = 2'b00;
    psr_write     = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'b00;
    instr_done    = 1'b0;
    state_out     = 2'b00;
    if (reset) begin
      state_out = r_state;
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_load = mem_ready;
        end
        S_EXEC: begin
          pc_en      = 1'b1;
          instr_done = 1'b1;
          case (op_code)
            OP_RTYPE: begin
              alu_A_src = 1'b1;
              alu_cont  = alu_code(2'b00, ext_op_code);
              reg_write = 1'b1;
              psr_write = 1'b1;
            end
            OP_SHIFT: begin
              alu_A_src = 1'b1;
              alu_B_src = ext_op_code[0];
              alu_cont  = alu_code(2'b10, ext_op_code);
              reg_write = 1'b1;
              psr_write = 1'b1;
            end
            OP_LUI: begin
              alu_B_src = 1'b1;
              alu_cont  = alu_code(2'b11, OP_BITS'(15));
              reg_write = 1'b1;
            end
            OP_BCOND: pc_src = w_cond ? 2'b10 : 2'b00;
            OP_SPEC: begin
              if (ext_op_code == EXT_JAL) begin
                reg_write     = 1'b1;
                reg_write_src = 2'b10;
                pc_src        = 2'b01;
              end else if (ext_op_code == EXT_JCOND) begin
                pc_src = w_cond ? 2'b01 : 2'b00;
              end
            end
            default: begin
              alu_A_src = 1'b1;
              alu_B_src = 1'b1;
              alu_cont  = alu_code(2'b00, op_code);
              reg_write = 1'b1;
              psr_write = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_src = 1'b1;
          mem_we       = (ext_op_code == EXT_STOR);
          if (mem_ready) begin
            if (ext_op_code == EXT_LOAD) begin
              reg_write     = 1'b1;
              reg_write_src = 2'b01;
            end
            pc_en      = 1'b1;
            instr_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected output
// vectors are queued with their stimulus and compared as the DUT steps.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op_code = '0, ext_op_code = '0, A_index = '0;
  logic [15:0] psr_flags = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_src, ir_load, alu_A_src, alu_B_src;
  logic [5:0]  alu_cont;
  logic        reg_write, psr_write, pc_en, instr_done;
  logic [1:0]  reg_write_src, pc_src, state_out;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [21:0] exp;
  } ent_t;
  ent_t sb[$];
  ent_t e;

  multicycle_controller #(.WIDTH(16), .OP_BITS(4), .ALU_CONT_BITS(6)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .ext_op_code(ext_op_code),
    .A_index(A_index), .psr_flags(psr_flags), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_src(mem_addr_src),
    .ir_load(ir_load), .alu_A_src(alu_A_src), .alu_B_src(alu_B_src),
    .alu_cont(alu_cont), .reg_write(reg_write), .reg_write_src(reg_write_src),
    .psr_write(psr_write), .pc_en(pc_en), .pc_src(pc_src),
    .instr_done(instr_done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // {state, req, we, addr_src, ir_load, A_src, B_src, alu_cont, rw, rw_src, psr_w, pc_en, pc_src, done}
  function automatic logic [21:0] ev(input logic [1:0] st, input logic req, we, asrc, irl,
                                     aa, ab, input logic [5:0] ac, input logic rw,
                                     input logic [1:0] rws, input logic pw, pe,
                                     input logic [1:0] ps, input logic dn);
    return {st, req, we, asrc, irl, aa, ab, ac, rw, rws, pw, pe, ps, dn};
  endfunction

  function automatic logic [21:0] obs();
    return {state_out, mem_req, mem_we, mem_addr_src, ir_load, alu_A_src, alu_B_src,
            alu_cont, reg_write, reg_write_src, psr_write, pc_en, pc_src, instr_done};
  endfunction

  function automatic logic [21:0] f_wait();
    return ev(2'd0, 1, 0, 0, 0, 0, 0, 6'd0, 0, 2'd0, 0, 0, 2'd0, 0);
  endfunction
  function automatic logic [21:0] f_rdy();
    return ev(2'd0, 1, 0, 0, 1, 0, 0, 6'd0, 0, 2'd0, 0, 0, 2'd0, 0);
  endfunction
  function automatic logic [21:0] dec();
    return ev(2'd1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 2'd0, 0, 0, 2'd0, 0);
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic [21:0] x);
    sb.push_back('{rst: rst, rdy: rdy, exp: x});
  endtask

  task automatic set_ir(input logic [15:0] ir);
    op_code = ir[15:12]; A_index = ir[11:8]; ext_op_code = ir[7:4];
  endtask

  task automatic test_reset();
    set_ir(16'h0153);
    push(0, 1, 22'd0);
    push(0, 1, 22'd0);
    push(1, 1, f_rdy());
    push(1, 1, dec());
    push(1, 1, ev(2'd2, 0, 0, 0, 0, 1, 0, 6'b000101, 1, 2'b00, 1, 1, 2'b00, 1));
    push(1, 0, f_wait());
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
      n_chk++;
      if (obs() !== e.exp) begin
        n_fail++; $display("FAIL reset_rtype: got %h expected %h", obs(), e.exp);
      end
    end
  endtask

  task automatic test_fetch_wait();
    set_ir(16'h4020);
    push(1, 0, f_wait()); push(1, 0, f_wait()); push(1, 0, f_wait());
    push(1, 1, f_rdy());
    push(1, 0, dec());
    push(1, 0, ev(2'd2, 0, 0, 0, 0, 0, 0, 6'd0, 0, 2'b00, 0, 1, 2'b00, 1));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
      n_chk++;
      if (obs() !== e.exp) begin
        n_fail++; $display("FAIL fetch_wait_nop: got %h expected %h", obs(), e.exp);
      end
    end
  endtask

  task automatic test_load_store();
    set_ir(16'h4300);
    push(1, 1, f_rdy());
    push(1, 1, dec());
    push(1, 0, ev(2'd3, 1, 0, 1, 0, 0, 0, 6'd0, 0, 2'b00, 0, 0, 2'b00, 0));
    push(1, 0, ev(2'd3, 1, 0, 1, 0, 0, 0, 6'd0, 0, 2'b00, 0, 0, 2'b00, 0));
    push(1, 1, ev(2'd3, 1, 0, 1, 0, 0, 0, 6'd0, 1, 2'b01, 0, 1, 2'b00, 1));
    push(1, 0, f_wait());
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
      n_chk++;
      if (obs() !== e.exp) begin
        n_fail++; $display("FAIL load: got %h expected %h", obs(), e.exp);
      end
    end
    set_ir(16'h4340);
    push(1, 1, f_rdy());
    push(1, 0, dec());
    push(1, 0, ev(2'd3, 1, 1, 1, 0, 0, 0, 6'd0, 0, 2'b00, 0, 0, 2'b00, 0));
    push(1, 1, ev(2'd3, 1, 1, 1, 0, 0, 0, 6'd0, 0, 2'b00, 0, 1, 2'b00, 1));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
      n_chk++;
      if (obs() !== e.exp) begin
        n_fail++; $display("FAIL stor: got %h expected %h", obs(), e.exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  cs [9] = '{4'h0, 4'h0, 4'hC, 4'hC, 4'hF, 4'hE, 4'h3, 4'hA, 4'hB};
    logic [15:0] fl [9] = '{16'h0040, 16'h0000, 16'h0000, 16'h0040, 16'hFFFF,
                            16'h0000, 16'h0001, 16'h0000, 16'h0004};
    logic [1:0]  ps [9] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 9; i++) begin
      set_ir({4'hC, cs[i], 8'h05});
      psr_flags = fl[i];
      push(1, 1, f_rdy());
      push(1, 1, dec());
      push(1, 0, ev(2'd2, 0, 0, 0, 0, 0, 0, 6'd0, 0, 2'b00, 0, 1, ps[i], 1));
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
        n_chk++;
        if (obs() !== e.exp) begin
          n_fail++; $display("FAIL bcond[%0d]: got %h expected %h", i, obs(), e.exp);
        end
      end
    end
    psr_flags = '0;
  endtask

  task automatic test_jump_alu();
    logic [15:0] ir [7] = '{16'h4280, 16'h4EC0, 16'h4FC0, 16'hF2AB, 16'h8310, 16'h8320, 16'h5234};
    logic [21:0] ex [7];
    ex[0] = ev(2'd2, 0, 0, 0, 0, 0, 0, 6'd0,      1, 2'b10, 0, 1, 2'b01, 1);
    ex[1] = ev(2'd2, 0, 0, 0, 0, 0, 0, 6'd0,      0, 2'b00, 0, 1, 2'b01, 1);
    ex[2] = ev(2'd2, 0, 0, 0, 0, 0, 0, 6'd0,      0, 2'b00, 0, 1, 2'b00, 1);
    ex[3] = ev(2'd2, 0, 0, 0, 0, 0, 1, 6'b111111, 1, 2'b00, 0, 1, 2'b00, 1);
    ex[4] = ev(2'd2, 0, 0, 0, 0, 1, 1, 6'b100001, 1, 2'b00, 1, 1, 2'b00, 1);
    ex[5] = ev(2'd2, 0, 0, 0, 0, 1, 0, 6'b100010, 1, 2'b00, 1, 1, 2'b00, 1);
    ex[6] = ev(2'd2, 0, 0, 0, 0, 1, 1, 6'b000101, 1, 2'b00, 1, 1, 2'b00, 1);
    psr_flags = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      set_ir(ir[i]);
      push(1, 1, f_rdy());
      push(1, 0, dec());
      push(1, 1, ex[i]);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
        n_chk++;
        if (obs() !== e.exp) begin
          n_fail++; $display("FAIL jump_alu[%0d]: got %h expected %h", i, obs(), e.exp);
        end
      end
    end
    psr_flags = '0;
  endtask

  task automatic test_reset_mid_mem();
    logic [3:0] ext [2] = '{4'h0, 4'h4};
    for (int i = 0; i < 2; i++) begin
      set_ir({8'h43, ext[i], 4'h0});
      push(1, 1, f_rdy());
      push(1, 1, dec());
      push(0, 1, 22'd0);
      push(1, 0, f_wait());
      push(1, 0, f_wait());
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk); reset = e.rst; mem_ready = e.rdy; #1;
        n_chk++;
        if (obs() !== e.exp) begin
          n_fail++; $display("FAIL reset_mid_mem[%0d]: got %h expected %h", i, obs(), e.exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_load_store();
    test_branch();
    test_jump_alu();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
